// File: rtl/d_uncache_axi_bridge_if.sv
// AXI3-style single-beat bus between the uncached data bridge (master) and the
// memory-side slave; only the ports the bridge uses are carried.
interface d_uncache_axi_bridge_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [3:0]  arcache;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [3:0]  awcache;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arcache, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arcache, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/d_uncache_axi_bridge.sv
// Single-outstanding uncached load/store bridge from the CPU data port to AXI.
// Optional macro UNCACHE_BYTE_STRB_EN: drive wstrb from the CPU byte enables.
module d_uncache_axi_bridge (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  uncache_en,
   input  logic                  uncache_rw,
   input  logic [29:0]           uncache_addr,
   input  logic [31:0]           uncache_wr_data,
   input  logic [3:0]            uncache_rwen,
   output logic [31:0]           uncache_rd_data,
   output logic                  uncache_data_ok,
   d_uncache_axi_bridge_if.master axi
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RADDR = 3'd1,
      RDATA = 3'd2,
      WRITE = 3'd3,
      WRESP = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [31:0] addr_r;
   logic [31:0] wr_data_r;
   logic        aw_done_r;
   logic        w_done_r;
   logic        aw_done_nxt_s;
   logic        w_done_nxt_s;
   logic        arvalid_r;
   logic        rready_r;
   logic        awvalid_r;
   logic        wvalid_r;
   logic        bready_r;
   logic        data_ok_r;
   logic [31:0] rd_data_r;
   logic        accept_s;
   logic        unused_s;

   assign accept_s = (state_r == IDLE) && uncache_en;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode and independent AW/W completion tracking
   always_comb begin
      state_nxt_s   = state_r;
      aw_done_nxt_s = 1'b0;
      w_done_nxt_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (uncache_en) begin
               state_nxt_s = uncache_rw ? WRITE : RADDR;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RADDR: begin
            if (arvalid_r && axi.arready) begin
               state_nxt_s = RDATA;
            end else begin
               state_nxt_s = RADDR;
            end
         end
         RDATA: begin
            if (rready_r && axi.rvalid) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = RDATA;
            end
         end
         WRITE: begin
            aw_done_nxt_s = aw_done_r || (awvalid_r && axi.awready);
            w_done_nxt_s  = w_done_r || (wvalid_r && axi.wready);
            if (aw_done_nxt_s && w_done_nxt_s) begin
               state_nxt_s = WRESP;
            end else begin
               state_nxt_s = WRITE;
            end
         end
         WRESP: begin
            if (bready_r && axi.bvalid) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = WRESP;
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Request capture; later CPU-side changes cannot disturb the bus
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_r    <= 32'd0;
         wr_data_r <= 32'd0;
      end else if (accept_s) begin
         addr_r    <= {uncache_addr, 2'b00};
         wr_data_r <= uncache_wr_data;
      end else begin
         addr_r    <= addr_r;
         wr_data_r <= wr_data_r;
      end
   end

   // Handshake outputs are registered from the next state so they are glitch-free
   always_ff @(posedge clk) begin
      if (reset) begin
         aw_done_r <= 1'b0;
         w_done_r  <= 1'b0;
         arvalid_r <= 1'b0;
         rready_r  <= 1'b0;
         awvalid_r <= 1'b0;
         wvalid_r  <= 1'b0;
         bready_r  <= 1'b0;
         data_ok_r <= 1'b0;
      end else begin
         aw_done_r <= (state_nxt_s == WRITE) ? aw_done_nxt_s : 1'b0;
         w_done_r  <= (state_nxt_s == WRITE) ? w_done_nxt_s : 1'b0;
         arvalid_r <= (state_nxt_s == RADDR);
         rready_r  <= (state_nxt_s == RDATA);
         awvalid_r <= (state_nxt_s == WRITE) && !aw_done_nxt_s;
         wvalid_r  <= (state_nxt_s == WRITE) && !w_done_nxt_s;
         bready_r  <= (state_nxt_s == WRESP);
         data_ok_r <= (state_nxt_s == DONE);
      end
   end

   // Load result holds until the next read completes
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_r <= 32'd0;
      end else if ((state_r == RDATA) && rready_r && axi.rvalid) begin
         rd_data_r <= axi.rdata;
      end else begin
         rd_data_r <= rd_data_r;
      end
   end

`ifdef UNCACHE_BYTE_STRB_EN
   logic [3:0] rwen_r;

   // Byte enables captured alongside the rest of the request
   always_ff @(posedge clk) begin
      if (reset) begin
         rwen_r <= 4'b0000;
      end else if (accept_s) begin
         rwen_r <= uncache_rwen;
      end else begin
         rwen_r <= rwen_r;
      end
   end

   assign axi.wstrb = rwen_r;
   assign unused_s  = &{1'b0, axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};
`else
   assign axi.wstrb = 4'b1111;
   assign unused_s  = &{1'b0, axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp,
                        uncache_rwen};
`endif

   assign axi.arid    = 4'd0;
   assign axi.araddr  = addr_r;
   assign axi.arlen   = 4'd0;
   assign axi.arsize  = 3'b010;
   assign axi.arburst = 2'b01;
   assign axi.arcache = 4'b0000;
   assign axi.arvalid = arvalid_r;
   assign axi.rready  = rready_r;

   assign axi.awid    = 4'd0;
   assign axi.awaddr  = addr_r;
   assign axi.awlen   = 4'd0;
   assign axi.awsize  = 3'b010;
   assign axi.awburst = 2'b01;
   assign axi.awcache = 4'b0000;
   assign axi.awvalid = awvalid_r;

   assign axi.wid     = 4'd0;
   assign axi.wdata   = wr_data_r;
   assign axi.wlast   = wvalid_r;
   assign axi.wvalid  = wvalid_r;
   assign axi.bready  = bready_r;

   assign uncache_rd_data = rd_data_r;
   assign uncache_data_ok = data_ok_r;

endmodule

// File: tb/tb_d_uncache_axi_bridge.sv
// Directed bench for d_uncache_axi_bridge: read, delayed-AW write, back-to-back,
// error response and mid-transaction reset, with hand-computed expectations.
module tb_d_uncache_axi_bridge;
   logic        clk;
   logic        reset;
   logic        uncache_en;
   logic        uncache_rw;
   logic [29:0] uncache_addr;
   logic [31:0] uncache_wr_data;
   logic [3:0]  uncache_rwen;
   logic [31:0] uncache_rd_data;
   logic        uncache_data_ok;
   int          errors;
   int          checks;

`ifdef UNCACHE_BYTE_STRB_EN
   localparam logic STRB_EN = 1'b1;
`else
   localparam logic STRB_EN = 1'b0;
`endif

   d_uncache_axi_bridge_if axi_bus ();

   d_uncache_axi_bridge dut (
      .clk             (clk),
      .reset           (reset),
      .uncache_en      (uncache_en),
      .uncache_rw      (uncache_rw),
      .uncache_addr    (uncache_addr),
      .uncache_wr_data (uncache_wr_data),
      .uncache_rwen    (uncache_rwen),
      .uncache_rd_data (uncache_rd_data),
      .uncache_data_ok (uncache_data_ok),
      .axi             (axi_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_idle(input string tag);
      chk({tag, " arvalid"}, 32'(axi_bus.arvalid), 32'd0);
      chk({tag, " awvalid"}, 32'(axi_bus.awvalid), 32'd0);
      chk({tag, " wvalid"},  32'(axi_bus.wvalid),  32'd0);
      chk({tag, " rready"},  32'(axi_bus.rready),  32'd0);
      chk({tag, " bready"},  32'(axi_bus.bready),  32'd0);
      chk({tag, " data_ok"}, 32'(uncache_data_ok), 32'd0);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b1;
      uncache_en = 1'b0;
      uncache_rw = 1'b0;
      uncache_addr = 30'd0;
      uncache_wr_data = 32'd0;
      uncache_rwen = 4'd0;
      axi_bus.arready = 1'b0;
      axi_bus.rid = 4'd0;
      axi_bus.rdata = 32'd0;
      axi_bus.rresp = 2'd0;
      axi_bus.rlast = 1'b0;
      axi_bus.rvalid = 1'b0;
      axi_bus.awready = 1'b0;
      axi_bus.wready = 1'b0;
      axi_bus.bid = 4'd0;
      axi_bus.bresp = 2'd0;
      axi_bus.bvalid = 1'b0;
      step();
      step();
      chk_all_idle("reset");
      chk("reset rd_data", uncache_rd_data, 32'd0);
      reset = 1'b0;

      // Read, slave ready tied high
      axi_bus.arready = 1'b1;
      axi_bus.rvalid = 1'b1;
      axi_bus.rlast = 1'b1;
      axi_bus.rdata = 32'hCAFE_F00D;
      uncache_en = 1'b1;
      uncache_rw = 1'b0;
      uncache_addr = 30'h0400_0001;
      step();
      chk("rd arvalid", 32'(axi_bus.arvalid), 32'd1);
      chk("rd araddr", axi_bus.araddr, 32'h1000_0004);
      chk("rd arfixed", {16'd0, axi_bus.arid, axi_bus.arlen, axi_bus.arsize, axi_bus.arburst,
                         axi_bus.arcache[2:0]}, {16'd0, 4'd0, 4'd0, 3'b010, 2'b01, 3'b000});
      chk("rd arcache", 32'(axi_bus.arcache), 32'd0);
      chk("rd ok early", 32'(uncache_data_ok), 32'd0);
      step();
      chk("rd rready", 32'(axi_bus.rready), 32'd1);
      chk("rd arvalid drop", 32'(axi_bus.arvalid), 32'd0);
      step();
      chk("rd data_ok", 32'(uncache_data_ok), 32'd1);
      chk("rd rd_data", uncache_rd_data, 32'hCAFE_F00D);
      uncache_en = 1'b0;
      step();
      chk("rd ok pulse end", 32'(uncache_data_ok), 32'd0);
      chk("rd rready drop", 32'(axi_bus.rready), 32'd0);
      axi_bus.rvalid = 1'b0;
      axi_bus.arready = 1'b0;

      // Write with AW accepted late, W accepted at once
      axi_bus.wready = 1'b1;
      uncache_en = 1'b1;
      uncache_rw = 1'b1;
      uncache_addr = 30'h0000_0010;
      uncache_wr_data = 32'h1234_5678;
      uncache_rwen = 4'b0011;
      step();
      chk("wr awvalid", 32'(axi_bus.awvalid), 32'd1);
      chk("wr wvalid", 32'(axi_bus.wvalid), 32'd1);
      chk("wr wlast", 32'(axi_bus.wlast), 32'd1);
      chk("wr awaddr", axi_bus.awaddr, 32'h0000_0040);
      chk("wr wdata", axi_bus.wdata, 32'h1234_5678);
      chk("wr wstrb", 32'(axi_bus.wstrb), STRB_EN ? 32'h3 : 32'hF);
      chk("wr awfixed", {16'd0, axi_bus.awid, axi_bus.awlen, axi_bus.awsize, axi_bus.awburst,
                         axi_bus.awcache[2:0]}, {16'd0, 4'd0, 4'd0, 3'b010, 2'b01, 3'b000});
      chk("wr wid", 32'({axi_bus.wid, axi_bus.awcache}), 32'd0);
      uncache_wr_data = 32'hFFFF_FFFF;
      uncache_addr = 30'h3FFF_FFFF;
      uncache_rwen = 4'b1100;
      step();
      chk("wr wvalid drop", 32'(axi_bus.wvalid), 32'd0);
      chk("wr wlast drop", 32'(axi_bus.wlast), 32'd0);
      chk("wr awvalid hold1", 32'(axi_bus.awvalid), 32'd1);
      chk("wr awaddr stable", axi_bus.awaddr, 32'h0000_0040);
      step();
      chk("wr awvalid hold2", 32'(axi_bus.awvalid), 32'd1);
      step();
      chk("wr awvalid hold3", 32'(axi_bus.awvalid), 32'd1);
      chk("wr bready early", 32'(axi_bus.bready), 32'd0);
      axi_bus.awready = 1'b1;
      step();
      chk("wr awvalid drop", 32'(axi_bus.awvalid), 32'd0);
      chk("wr bready", 32'(axi_bus.bready), 32'd1);
      chk("wr ok early", 32'(uncache_data_ok), 32'd0);
      axi_bus.awready = 1'b0;
      axi_bus.bvalid = 1'b1;
      step();
      chk("wr data_ok", 32'(uncache_data_ok), 32'd1);
      chk("wr bready drop", 32'(axi_bus.bready), 32'd0);
      chk("wr keeps rd_data", uncache_rd_data, 32'hCAFE_F00D);

      // Back-to-back read presented with en still high
      axi_bus.bvalid = 1'b0;
      axi_bus.arready = 1'b1;
      axi_bus.rvalid = 1'b1;
      axi_bus.rdata = 32'hA5A5_5A5A;
      uncache_rw = 1'b0;
      uncache_addr = 30'h0000_0100;
      step();
      chk("b2b idle ok", 32'(uncache_data_ok), 32'd0);
      chk("b2b idle arvalid", 32'(axi_bus.arvalid), 32'd0);
      step();
      chk("b2b arvalid", 32'(axi_bus.arvalid), 32'd1);
      chk("b2b araddr", axi_bus.araddr, 32'h0000_0400);
      chk("b2b no extra ok", 32'(uncache_data_ok), 32'd0);
      step();
      chk("b2b rready", 32'(axi_bus.rready), 32'd1);
      step();
      chk("b2b data_ok", 32'(uncache_data_ok), 32'd1);
      chk("b2b rd_data", uncache_rd_data, 32'hA5A5_5A5A);
      uncache_en = 1'b0;
      step();
      chk("b2b ok pulse end", 32'(uncache_data_ok), 32'd0);

      // Write with SLVERR response, slave ready tied high
      axi_bus.arready = 1'b0;
      axi_bus.rvalid = 1'b0;
      axi_bus.awready = 1'b1;
      axi_bus.wready = 1'b1;
      axi_bus.bvalid = 1'b1;
      axi_bus.bresp = 2'b10;
      uncache_en = 1'b1;
      uncache_rw = 1'b1;
      uncache_addr = 30'h0000_0020;
      uncache_wr_data = 32'hDEAD_BEEF;
      uncache_rwen = 4'b0100;
      step();
      chk("err awvalid", 32'(axi_bus.awvalid), 32'd1);
      chk("err wvalid", 32'(axi_bus.wvalid), 32'd1);
      chk("err awaddr", axi_bus.awaddr, 32'h0000_0080);
      chk("err wdata", axi_bus.wdata, 32'hDEAD_BEEF);
      chk("err wstrb", 32'(axi_bus.wstrb), STRB_EN ? 32'h4 : 32'hF);
      step();
      chk("err bready", 32'(axi_bus.bready), 32'd1);
      chk("err valids drop", 32'({axi_bus.awvalid, axi_bus.wvalid}), 32'd0);
      step();
      chk("err data_ok", 32'(uncache_data_ok), 32'd1);
      chk("err keeps rd_data", uncache_rd_data, 32'hA5A5_5A5A);
      uncache_en = 1'b0;
      axi_bus.bvalid = 1'b0;
      axi_bus.bresp = 2'b00;
      step();
      chk("err ok pulse end", 32'(uncache_data_ok), 32'd0);
      step();
      chk("err single ok", 32'(uncache_data_ok), 32'd0);

      // Reset while waiting in RDATA
      axi_bus.awready = 1'b0;
      axi_bus.wready = 1'b0;
      axi_bus.arready = 1'b1;
      uncache_en = 1'b1;
      uncache_rw = 1'b0;
      uncache_addr = 30'h0000_0040;
      step();
      chk("rst arvalid", 32'(axi_bus.arvalid), 32'd1);
      step();
      chk("rst in rdata", 32'(axi_bus.rready), 32'd1);
      reset = 1'b1;
      uncache_en = 1'b0;
      step();
      chk_all_idle("midrst");
      chk("midrst rd_data", uncache_rd_data, 32'd0);
      reset = 1'b0;
      step();
      step();
      chk_all_idle("postrst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
